// File: rtl/mux_select_arbiter_pkg.sv
// Shared definitions for the mux select arbiter.
// Contents: requester count, select width, FSM state encoding and a one-hot helper.
package mux_select_arbiter_pkg;

  localparam int unsigned NReq = 4;
  localparam int unsigned SelW = 2;

  // Encodings are fixed so that state values match the TTL model's shared header.
  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StSettle  = 2'd1,
    StGrant   = 2'd2,
    StRelease = 2'd3
  } arb_state_e;

  function automatic logic [NReq-1:0] onehot_of(input logic [SelW-1:0] idx);
    logic [NReq-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mux_select_arbiter_if.sv
// Bus between the requesters and the mux select arbiter.
// Signals: req (requester levels), gnt (one-hot grant), sel (mux address {A1,A0}),
//          strobe_n (active-low mux enable), busy (arbiter not idle).
// Modports: master = requester side, slave = arbiter side.
interface mux_select_arbiter_if;
  import mux_select_arbiter_pkg::*;

  logic [NReq-1:0] req;
  logic [NReq-1:0] gnt;
  logic [SelW-1:0] sel;
  logic            strobe_n;
  logic            busy;

  modport master (output req, input gnt, sel, strobe_n, busy);
  modport slave  (input req, output gnt, sel, strobe_n, busy);

endinterface

// File: rtl/mux_select_arbiter_rr_pick4.sv
// Combinational round-robin picker for four requesters.
// Ports: req_i  - request levels
//        last_i - index of the previous owner
//        idx_o  - first set request scanning last+1, last+2, ... (mod 4)
//        any_o  - at least one request is set
module mux_select_arbiter_rr_pick4
  import mux_select_arbiter_pkg::*;
(
  input  logic [NReq-1:0] req_i,
  input  logic [SelW-1:0] last_i,
  output logic [SelW-1:0] idx_o,
  output logic            any_o
);

  logic [SelW-1:0] cand;

  // Scan from the lowest priority upward so the highest-priority hit is the last write.
  always_comb begin
    idx_o = last_i;
    any_o = 1'b0;
    cand  = '0;
    for (int k = NReq; k > 0; k--) begin
      cand = last_i + SelW'(k);
      if (req_i[cand]) begin
        idx_o = cand;
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_select_arbiter.sv
// Round-robin arbiter sharing one dual 4-to-1 select mux among four requesters.
// Break-before-make: the select is settled with the strobe high before every grant and the
// strobe is raised for a release cycle before the select may move again.
// Ports: clk      - rising-edge clock
//        reset    - synchronous, active-high reset
//        bus      - slave side of mux_select_arbiter_if (req in; gnt, sel, strobe_n, busy out)
// Parameters: SETTLE_CYCLES - cycles of settled select before grant (0 skips SETTLE)
//             MAX_HOLD      - grant cycles before forced release when others wait (0 = no limit)
//             HOLD_W        - hold counter width, must be able to hold MAX_HOLD
module mux_select_arbiter
  import mux_select_arbiter_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned MAX_HOLD      = 16,
  parameter int unsigned HOLD_W        = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  mux_select_arbiter_if.slave  bus
);

  localparam int unsigned SettleW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SettleW-1:0] SettleLast = SettleW'(SETTLE_CYCLES - 1);
  localparam logic [HOLD_W-1:0]  MaxHoldV   = HOLD_W'(MAX_HOLD);

  arb_state_e        state_q;
  logic [NReq-1:0]   gnt_q;
  logic [SelW-1:0]   sel_q;     // doubles as the current owner index
  logic [SelW-1:0]   last_q;
  logic              strobe_n_q;
  logic [HOLD_W-1:0] hold_q;
  logic [SettleW-1:0] settle_q;

  logic [SelW-1:0] pick_idx;
  logic            pick_any;
  logic            others_wait;
  logic            forced;

  mux_select_arbiter_rr_pick4 u_pick (
    .req_i  (bus.req),
    .last_i (last_q),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  assign others_wait = |(bus.req & ~onehot_of(sel_q));
  assign forced      = (MAX_HOLD != 0) && (hold_q == MaxHoldV) && others_wait;

  // hold_q counts grant cycles including the current one, so release comes after MAX_HOLD.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      gnt_q      <= '0;
      sel_q      <= '0;
      last_q     <= SelW'(NReq - 1);
      strobe_n_q <= 1'b1;
      hold_q     <= '0;
      settle_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pick_any) begin
            sel_q    <= pick_idx;
            settle_q <= '0;
            if (SETTLE_CYCLES == 0) begin
              state_q    <= StGrant;
              gnt_q      <= onehot_of(pick_idx);
              strobe_n_q <= 1'b0;
              hold_q     <= HOLD_W'(1);
            end else begin
              state_q <= StSettle;
            end
          end
        end
        StSettle: begin
          if (!bus.req[sel_q]) begin
            state_q <= StRelease;
          end else if (settle_q == SettleLast) begin
            state_q    <= StGrant;
            gnt_q      <= onehot_of(sel_q);
            strobe_n_q <= 1'b0;
            hold_q     <= HOLD_W'(1);
          end else begin
            settle_q <= settle_q + SettleW'(1);
          end
        end
        StGrant: begin
          if (!bus.req[sel_q] || forced) begin
            state_q    <= StRelease;
            gnt_q      <= '0;
            strobe_n_q <= 1'b1;
          end else if ((MAX_HOLD != 0) && (hold_q != MaxHoldV)) begin
            hold_q <= hold_q + HOLD_W'(1);
          end
        end
        StRelease: begin
          state_q <= StIdle;
          last_q  <= sel_q;
          hold_q  <= '0;
        end
      endcase
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.sel      = sel_q;
  assign bus.strobe_n = strobe_n_q;
  assign bus.busy     = (state_q != StIdle);

endmodule

// File: tb/tb_mux_select_arbiter.sv
// Self-checking bench for mux_select_arbiter: directed stimulus pushes expected grants
// (owner, length, gap) into a queue; a negedge monitor pops and compares each grant and
// checks the bus invariants every cycle.
module tb_mux_select_arbiter;
  import mux_select_arbiter_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mux_select_arbiter_if bus ();

  mux_select_arbiter #(
    .SETTLE_CYCLES (1),
    .MAX_HOLD      (16),
    .HOLD_W        (5)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0] gnt;
    int         len;  // 0 = don't care
    int         gap;  // 0 = don't care
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  logic mon_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic push(input logic [3:0] g, input int len, input int gap);
    exp_t e;
    e.gnt = g;
    e.len = len;
    e.gap = gap;
    exp_q.push_back(e);
  endtask

  task automatic wait_gnt(input logic [3:0] g, input int max_cyc);
    int n = 0;
    while (bus.gnt !== g && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.gnt !== g) begin
      failures++;
      $display("FAIL wait_gnt: got %b required %b within %0d cycles", bus.gnt, g, max_cyc);
    end
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    bus.req = '0;
    @(negedge clk);
    @(negedge clk);
    reset  = 1'b0;
    mon_en = 1'b1;
  endtask

  // Monitor: grant scoreboard plus per-cycle invariants.
  logic [3:0] prev_gnt = '0;
  logic       prev_strobe_n = 1'b1;
  logic [1:0] prev_sel = '0;
  int         run_len = 0;
  int         gap_len = 0;
  logic       cur_valid = 1'b0;
  exp_t       cur;

  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (!$onehot0(bus.gnt) || ((bus.gnt != 4'b0) == bus.strobe_n) ||
          (!prev_strobe_n && !bus.strobe_n && bus.sel != prev_sel)) begin
        failures++;
        $display("FAIL invariant: gnt=%b strobe_n=%b sel=%0d prev_sel=%0d required one-hot gnt, gnt!=0 iff strobe_n=0, sel stable",
                 bus.gnt, bus.strobe_n, bus.sel, prev_sel);
      end
      if (bus.gnt != 4'b0 && prev_gnt == 4'b0) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_grant: got %b required none", bus.gnt);
          cur_valid = 1'b0;
        end else begin
          cur = exp_q.pop_front();
          cur_valid = 1'b1;
          check("grant_owner", 32'(bus.gnt), 32'(cur.gnt));
          if (cur.gap != 0) check("grant_gap", 32'(gap_len), 32'(cur.gap));
        end
        run_len = 1;
      end else if (bus.gnt != 4'b0) begin
        run_len++;
      end else if (prev_gnt != 4'b0) begin
        if (cur_valid && cur.len != 0) check("grant_len", 32'(run_len), 32'(cur.len));
        cur_valid = 1'b0;
        gap_len   = 1;
      end else begin
        gap_len++;
      end
      prev_gnt      = bus.gnt;
      prev_strobe_n = bus.strobe_n;
      prev_sel      = bus.sel;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.req = '0;

    // Reset state and single-request latency.
    do_reset();
    check("rst_gnt", 32'(bus.gnt), 32'h0);
    check("rst_sel", 32'(bus.sel), 32'h0);
    check("rst_strobe_n", 32'(bus.strobe_n), 32'h1);
    check("rst_busy", 32'(bus.busy), 32'h0);
    push(4'b0001, 2, 0);
    bus.req = 4'b0001;
    @(negedge clk);
    check("lat_e0_sel", 32'(bus.sel), 32'h0);
    check("lat_e0_strobe_n", 32'(bus.strobe_n), 32'h1);
    check("lat_e0_gnt", 32'(bus.gnt), 32'h0);
    check("lat_e0_busy", 32'(bus.busy), 32'h1);
    @(negedge clk);
    check("lat_e1_gnt", 32'(bus.gnt), 32'h1);
    check("lat_e1_strobe_n", 32'(bus.strobe_n), 32'h0);
    @(negedge clk);
    bus.req = '0;
    @(negedge clk);
    @(negedge clk);
    check("idle_busy", 32'(bus.busy), 32'h0);

    // All four requesting: round-robin order 0,1,2,3,0 with three-cycle gaps.
    do_reset();
    push(4'b0001, 2, 0);
    push(4'b0010, 2, 3);
    push(4'b0100, 2, 3);
    push(4'b1000, 2, 3);
    push(4'b0001, 2, 3);
    bus.req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      logic [3:0] g;
      g = 4'b0001 << (i % 4);
      wait_gnt(g, 10);
      @(negedge clk);
      bus.req = bus.req & ~g;
      @(negedge clk);
      bus.req = (i < 4) ? 4'b1111 : 4'b0000;
    end
    repeat (4) @(negedge clk);

    // req0 held, req2 arrives: forced release after 16 grant cycles, then req2.
    do_reset();
    push(4'b0001, 16, 0);
    push(4'b0100, 1, 3);
    bus.req = 4'b0001;
    repeat (5) @(negedge clk);
    bus.req = 4'b0101;
    wait_gnt(4'b0100, 40);
    bus.req = '0;
    repeat (4) @(negedge clk);

    // req0 alone: no forced release, grant lasts 40 cycles.
    do_reset();
    push(4'b0001, 40, 0);
    bus.req = 4'b0001;
    wait_gnt(4'b0001, 5);
    repeat (39) @(negedge clk);
    bus.req = '0;
    repeat (4) @(negedge clk);

    // Reset during grant of owner 2, then 0101 grants owner 0 first.
    do_reset();
    push(4'b0100, 0, 0);
    bus.req = 4'b0100;
    wait_gnt(4'b0100, 5);
    @(negedge clk);
    reset   = 1'b1;
    bus.req = '0;
    @(negedge clk);
    check("midrst_gnt", 32'(bus.gnt), 32'h0);
    check("midrst_strobe_n", 32'(bus.strobe_n), 32'h1);
    check("midrst_sel", 32'(bus.sel), 32'h0);
    check("midrst_busy", 32'(bus.busy), 32'h0);
    reset = 1'b0;
    push(4'b0001, 1, 0);
    push(4'b0100, 1, 3);
    bus.req = 4'b0101;
    wait_gnt(4'b0001, 5);
    bus.req = 4'b0100;
    wait_gnt(4'b0100, 10);
    bus.req = '0;
    repeat (4) @(negedge clk);

    // One-cycle req1 pulse: SETTLE then RELEASE, never granted.
    do_reset();
    bus.req = 4'b0010;
    @(negedge clk);
    bus.req = '0;
    check("pulse_settle_sel", 32'(bus.sel), 32'h1);
    check("pulse_settle_busy", 32'(bus.busy), 32'h1);
    check("pulse_settle_gnt", 32'(bus.gnt), 32'h0);
    @(negedge clk);
    check("pulse_release_busy", 32'(bus.busy), 32'h1);
    check("pulse_release_strobe_n", 32'(bus.strobe_n), 32'h1);
    @(negedge clk);
    check("pulse_idle_busy", 32'(bus.busy), 32'h0);
    check("pulse_idle_gnt", 32'(bus.gnt), 32'h0);
    repeat (3) @(negedge clk);

    check("scoreboard_drain", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
